// File: rtl/addr_gen_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NREQ
// address-generator requesters, with tagged read return and done aggregation.
module addr_gen_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [NREQ-1:0]        enable,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_done,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [NREQ-1:0]        rdata_valid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   all_done
);

  localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  logic [IW-1:0]     prio;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     gidx;
  logic              found;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IW-1:0]     tag1, tag2;
  logic              rd1, rd2;
  logic [NREQ-1:0]   done_flag;

  assign elig = req_valid & enable & {NREQ{~run}};

  // Scan starts at prio and wraps modulo NREQ; the first eligible index wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!found && elig[IW'((32'(prio) + k) % NR)]) begin
        found = 1'b1;
        gidx  = IW'((32'(prio) + k) % NR);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag1      <= '0;
      rd1       <= 1'b0;
      tag2      <= '0;
      rd2       <= 1'b0;
      done_flag <= '0;
      all_done  <= 1'b0;
    end else begin
      if (found) begin
        mem_en    <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        tag1      <= gidx;
        rd1       <= ~sel_we;
        prio      <= IW'((32'(gidx) + 1) % NR);
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        rd1    <= 1'b0;
      end
      if (run) prio <= '0;

      rd2  <= rd1;
      tag2 <= tag1;

      if (run) begin
        done_flag <= '0;
        all_done  <= 1'b0;
      end else begin
        done_flag <= done_flag | req_done;
        all_done  <= (&(done_flag | ~enable)) & ~mem_en & ~rd2;
      end
    end
  end

  always_comb begin
    rdata_valid = '0;
    if (rd2) rdata_valid[tag2] = 1'b1;
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_addr_gen_port_arbiter.sv
// Directed plus randomized bench for addr_gen_port_arbiter against a
// transaction-history reference model and a behavioural synchronous memory.
module tb_addr_gen_port_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, run;
  logic [NREQ-1:0]        enable, req_valid, req_we, req_done;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready, rdata_valid;
  logic                   mem_en, mem_we, all_done;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata, mem_rdata, rdata;

  addr_gen_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .run(run), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_done(req_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .all_done(all_done)
  );

  // Behavioural single-port synchronous memory attached to the DUT port.
  logic [DATA_W-1:0] bmem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bmem[mem_addr];
    end
  end

  typedef struct {
    bit          v;
    int          idx;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
  } beat_t;

  // Reference state: memory contents, pointer, done flags, beat history.
  logic [DATA_W-1:0] mmem [0:(1<<ADDR_W)-1];
  int              mprio;
  bit [NREQ-1:0]   mdone;
  bit              mad;
  beat_t           hist[$];
  bit              after_rst;

  int total = 0;
  int bad   = 0;

  logic              d_rst, d_run;
  logic [NREQ-1:0]   d_en, d_valid, d_we, d_done;
  int                d_addr  [NREQ];
  logic [DATA_W-1:0] d_wdata [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beat_t e;
    e = '{v: 0, idx: 0, we: 0, addr: 0, wdata: '0, rdat: '0};
    hist = {};
    repeat (3) hist.push_front(e);
    mprio = 0;
    mdone = '0;
    mad   = 1'b0;
  endtask

  task automatic idle();
    d_rst = 0; d_run = 0; d_valid = '0; d_we = '0; d_done = '0;
  endtask

  task automatic tick();
    beat_t           b;
    int              g;
    logic [NREQ-1:0] exp_ready, exp_rv;
    bit              nad;
    rst = d_rst; run = d_run; enable = d_en;
    req_valid = d_rst ? '0 : d_valid;
    req_we = d_we; req_done = d_done;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(d_addr[i]);
      req_wdata[i*DATA_W +: DATA_W] = d_wdata[i];
    end
    #1;
    g = -1;
    if (!d_run)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mprio + k) % NREQ;
        if (g < 0 && req_valid[i] && d_en[i]) g = i;
      end
    if (!d_rst) begin
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("mem_en", 64'(mem_en), 64'(hist[0].v));
      if (hist[0].v) begin
        chk("mem_we", 64'(mem_we), 64'(hist[0].we));
        chk("mem_addr", 64'(mem_addr), 64'(hist[0].addr));
        if (hist[0].we) chk("mem_wdata", 64'(mem_wdata), 64'(hist[0].wdata));
      end
      if (after_rst) begin
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      end
      exp_rv = '0;
      if (hist[1].v && !hist[1].we) exp_rv[hist[1].idx] = 1'b1;
      chk("rdata_valid", 64'(rdata_valid), 64'(exp_rv));
      if (exp_rv != '0) chk("rdata", 64'(rdata), 64'(hist[1].rdat));
      chk("all_done", 64'(all_done), 64'(mad));
    end
    if (d_rst) begin
      model_reset();
    end else begin
      nad = !d_run && !hist[0].v && !(hist[1].v && !hist[1].we);
      for (int i = 0; i < NREQ; i++) if (!(mdone[i] || !d_en[i])) nad = 0;
      b = '{v: 0, idx: 0, we: 0, addr: 0, wdata: '0, rdat: '0};
      if (g >= 0) begin
        b.v = 1; b.idx = g; b.we = d_we[g]; b.addr = d_addr[g]; b.wdata = d_wdata[g];
        if (b.we) mmem[b.addr] = b.wdata;
        else      b.rdat = mmem[b.addr];
        mprio = (g + 1) % NREQ;
      end
      if (d_run) mprio = 0;
      hist.push_front(b);
      void'(hist.pop_back());
      mdone = d_run ? '0 : (mdone | d_done);
      mad = nad;
    end
    after_rst = d_rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      bmem[a] = $urandom;
      mmem[a] = bmem[a];
    end
    for (int i = 0; i < NREQ; i++) begin
      d_addr[i] = 0; d_wdata[i] = '0;
    end
    after_rst = 0;
    model_reset();
    idle(); d_en = '0;

    // reset
    d_rst = 1; tick(); tick();
    idle(); tick();

    // enable mask: only requester 0 can be granted
    d_run = 1; d_en = 4'b0001; tick();
    idle(); d_valid = 4'b1111; d_addr[0] = 5; tick();
    idle(); tick(); tick(); tick();

    // round-robin, all valid from prio 0
    d_run = 1; d_en = 4'b1111; tick();
    idle();
    for (int c = 0; c < 8; c++) begin
      d_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) d_addr[i] = 8 + i + c;
      tick();
    end
    idle(); tick(); tick();

    // pointer skip with a write from requester 3
    d_run = 1; tick();
    idle(); d_valid = 4'b0010; d_addr[1] = 3; tick();
    d_valid = 4'b1010; d_addr[1] = 7; d_addr[3] = 7; d_we = 4'b1000; d_wdata[3] = 32'hA5;
    tick(); tick(); tick();
    idle(); tick(); tick(); tick();

    // run while requester 2 is valid
    d_valid = 4'b0100; d_addr[2] = 11; tick();
    d_run = 1; tick();
    d_run = 0; tick();
    idle(); tick(); tick(); tick();

    // done aggregation with a read outstanding at the last pulse
    d_run = 1; d_en = 4'b0111; tick();
    idle(); d_done = 4'b0001; tick();
    idle(); tick();
    d_done = 4'b0100; tick();
    idle(); d_valid = 4'b0010; d_addr[1] = 12; d_done = 4'b0010; tick();
    idle();
    repeat (6) tick();
    d_run = 1; tick();
    idle(); tick(); tick();

    // done coinciding with run is discarded
    d_run = 1; d_done = 4'b0111; tick();
    idle(); repeat (4) tick();

    // reset one cycle after a read handshake
    d_run = 1; d_en = 4'b1111; tick();
    idle(); d_valid = 4'b0001; d_addr[0] = 20; tick();
    idle(); d_rst = 1; tick();
    idle(); repeat (4) tick();

    // randomized traffic
    d_run = 1; tick();
    for (int c = 0; c < 500; c++) begin
      idle();
      d_en    = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : 4'b1111;
      d_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      d_we    = NREQ'($urandom);
      d_done  = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      d_run   = ($urandom_range(0, 29) == 0);
      d_rst   = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NREQ; i++) begin
        d_addr[i]  = $urandom_range(0, 31);
        d_wdata[i] = $urandom;
      end
      tick();
    end
    idle(); repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
